// File: rtl/io_pkg.sv
// io_pkg: shared constants and types for the IO bridge.
// Holds the IO window base, the peripheral offset table, the load FSM state type
// and the data returned for a load to an unmapped offset.
package io_pkg;

   localparam logic [19:0] IO_BASE_DEFAULT = 20'hFFFFF;

   // Peripheral offsets inside the 4 KiB IO window
   localparam logic [11:0] LED_ADDR    = 12'h060;
   localparam logic [11:0] SWITCH_ADDR = 12'h070;
   localparam logic [11:0] TUBE_ADDR   = 12'h000;

   // Returned for loads that hit the window but match no device
   localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      ISSUE,
      WAIT,
      DONE
   } ld_state_t;

   // True when the offset belongs to a peripheral in the table above
   function automatic logic dev_known(input logic [11:0] off);
      return (off == LED_ADDR) || (off == SWITCH_ADDR) || (off == TUBE_ADDR);
   endfunction

endpackage

// File: rtl/io_wr_fifo.sv
// io_wr_fifo: small synchronous FIFO holding posted stores.
// Depth 2^AW, pointers are AW+1 bits so full and empty are told apart by the MSB.
// The head entry is read combinationally so a strobe can follow a push by one cycle.
module io_wr_fifo #(
   parameter int AW = 2,
   parameter int W  = 44
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int DEPTH = 1 << AW;

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         do_push;
   logic         do_pop;

   // Flags derive only from the pointer registers, so a same-cycle pop never frees a slot early
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   assign wr_ptr_d = do_push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
   assign rd_ptr_d = do_pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;

   assign head_o = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer registers; reset discards every queued entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage; contents are only observed while the FIFO is not empty
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/io_bridge.sv
// io_bridge: CPU memory stage to memory-mapped peripheral bridge.
// Stores that hit the IO window are posted into io_wr_fifo and replayed one per cycle
// as dv_wr_e strobes; loads wait for the FIFO to drain, then issue one dv_rd_e.
// A load stalls its request cycle and then walks DRAIN/ISSUE/WAIT/DONE: four cycles from
// DRAIN onward with the stall held for three of them, dropping in DONE with cpu_rdata valid.
// Optional feature macro IO_BRIDGE_ERR_EN: offsets outside the device table raise a sticky
// err_flag, loads return DEADBEEF without a device read, and stores are dropped.
module io_bridge
   import io_pkg::*;
#(
   parameter logic [19:0] IO_BASE = IO_BASE_DEFAULT,
   parameter int          FIFO_AW = 2,
   parameter int          DW      = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   cpu_addr,
   input  logic          cpu_wr_e,
   input  logic          cpu_rd_e,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_stall,
   output logic [DW-1:0] cpu_rdata,
   output logic          dv_wr_e,
   output logic          dv_rd_e,
   output logic [11:0]   dv_addr,
   output logic [DW-1:0] dv_wdata,
   input  logic [DW-1:0] dv_rdata,
   input  logic          dv_busy
`ifdef IO_BRIDGE_ERR_EN
   ,
   output logic          err_flag
`endif
);

   ld_state_t       state_q;
   logic [11:0]     ld_addr_q;
   logic            ld_bad_q;
   logic [DW-1:0]   cpu_rdata_q;

   logic            hit;
   logic [11:0]     off;
   logic            off_bad;
   logic            st_hit;
   logic            st_ok;
   logic            ld_hit;
   logic            idle;
   logic            drain_ok;
   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [11+DW:0]  fifo_head;
   logic            stall_raw;

   // Address decode
   assign hit = (cpu_addr[31:12] == IO_BASE);
   assign off = cpu_addr[11:0];

`ifdef IO_BRIDGE_ERR_EN
   assign off_bad = !dev_known(off);
`else
   assign off_bad = 1'b0;
`endif

   // A store wins over a simultaneous load; unmapped stores are simply dropped
   assign st_hit = cpu_wr_e && hit;
   assign st_ok  = st_hit && !off_bad;
   assign ld_hit = cpu_rd_e && !cpu_wr_e && hit;
   assign idle   = (state_q == IDLE);

   // The FIFO keeps draining while a load waits for it to empty
   assign drain_ok  = (state_q == IDLE) || (state_q == DRAIN);
   assign fifo_pop  = !fifo_empty && !dv_busy && drain_ok;
   assign fifo_push = st_ok && idle && !fifo_full;

   io_wr_fifo #(
      .AW (FIFO_AW),
      .W  (12 + DW)
   ) u_wr_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i ({off, cpu_wdata}),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Stall: store blocked by a full FIFO or a load in flight, or any load not yet in DONE.
   // Gated by rst_n so a request held across reset cannot freeze the pipeline.
   assign stall_raw = (st_ok && (fifo_full || !idle))
                    || (state_q == DRAIN) || (state_q == ISSUE) || (state_q == WAIT)
                    || (idle && ld_hit);
   assign cpu_stall = rst_n && stall_raw;

   // Device bus: the FIFO head registers or the captured load offset, zero otherwise
   assign dv_wr_e  = fifo_pop;
   assign dv_rd_e  = (state_q == ISSUE);
   assign dv_addr  = fifo_pop ? fifo_head[11+DW:DW] : (dv_rd_e ? ld_addr_q : 12'h000);
   assign dv_wdata = fifo_pop ? fifo_head[DW-1:0] : '0;
   assign cpu_rdata = cpu_rdata_q;

   // Load FSM: order the read behind posted stores, issue it, capture the result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ld_addr_q   <= 12'h000;
         ld_bad_q    <= 1'b0;
         cpu_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ld_hit) begin
                  state_q   <= DRAIN;
                  ld_addr_q <= off;
                  ld_bad_q  <= off_bad;
               end
            end
            DRAIN: begin
               if (fifo_empty && !dv_busy) begin
                  state_q <= ld_bad_q ? WAIT : ISSUE;
               end
            end
            ISSUE: begin
               state_q <= WAIT;
            end
            WAIT: begin
               cpu_rdata_q <= ld_bad_q ? DW'(DEADBEEF) : dv_rdata;
               state_q     <= DONE;
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef IO_BRIDGE_ERR_EN
   logic err_q;

   // Sticky error on any window access to an unmapped offset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if ((st_hit && off_bad) || (idle && ld_hit && off_bad)) begin
         err_q <= 1'b1;
      end
   end

   assign err_flag = err_q;
`endif

endmodule
